nios2_ocimem_dbg_ctrl: RTL

- Sysclk-domain consumer of the debug-slave command outputs: `jdo` plus the `take_action_ocimem_*` strobes.
- Decodes on-chip-memory debug commands and runs single-word reads and writes on an Avalon-style master port into the OCI debug RAM/ROM, with address auto-increment.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG side for scan-out.
- Sits between the debug-slave wrapper and the CPU's OCI memory.

---
 rtl/nios2_ocimem_dbg_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nios2_ocimem_dbg_ctrl.sv
// OCI debug-memory command engine: decodes debug-slave strobes into single-word Avalon reads/writes.
// Optional write read-back verify is compiled in with OCIMEM_WR_VERIFY_EN.
module nios2_ocimem_dbg_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

`ifdef OCIMEM_WR_VERIFY_EN
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_VFY} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;
`endif

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mon_q;
  logic              rd_q, wr_q, rdy_q, err_q, inc_q, ld_pend_q;
  logic [7:0]        wait_cnt_q;

  logic              any_stb_d, conflict_d, timeout_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic              unused_jdo;

  assign any_stb_d  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign conflict_d = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);
  assign timeout_d  = mem_waitrequest && (wait_cnt_q == TO_LAST);
  assign addr_inc_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      mon_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      inc_q      <= 1'b0;
      ld_pend_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      ld_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // An address-only load reports ready one cycle after the load.
          if (ld_pend_q) rdy_q <= 1'b1;
          if (take_action_ocimem_a) begin
            addr_q <= jdo[ADDR_W+16:17];
            rdy_q  <= 1'b0;
            if (jdo[36]) err_q <= 1'b0;
            if (jdo[35]) begin
              state_q    <= S_RD;
              rd_q       <= 1'b1;
              inc_q      <= 1'b0;
              wait_cnt_q <= '0;
            end else begin
              ld_pend_q <= 1'b1;
            end
          end else if (take_action_ocimem_b) begin
            wdata_q    <= jdo[34:3];
            state_q    <= S_WR;
            wr_q       <= 1'b1;
            inc_q      <= 1'b1;
            rdy_q      <= 1'b0;
            wait_cnt_q <= '0;
          end else if (take_no_action_ocimem_a) begin
            state_q    <= S_RD;
            rd_q       <= 1'b1;
            inc_q      <= 1'b1;
            rdy_q      <= 1'b0;
            wait_cnt_q <= '0;
          end
          // Placed after the clear so a conflicting clear command still flags.
          if (conflict_d) err_q <= 1'b1;
        end

        S_RD: begin
          if (!mem_waitrequest) begin
            mon_q   <= mem_rdata;
            rd_q    <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
            if (inc_q) addr_q <= addr_inc_d;
          end else if (timeout_d) begin
            rd_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
          if (any_stb_d) err_q <= 1'b1;
        end

        S_WR: begin
          if (!mem_waitrequest) begin
            wr_q <= 1'b0;
`ifdef OCIMEM_WR_VERIFY_EN
            // One idle bus cycle, then the read-back is issued from S_VFY.
            state_q    <= S_VFY;
            wait_cnt_q <= '0;
`else
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
            if (inc_q) addr_q <= addr_inc_d;
`endif
          end else if (timeout_d) begin
            wr_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
          if (any_stb_d) err_q <= 1'b1;
        end

`ifdef OCIMEM_WR_VERIFY_EN
        S_VFY: begin
          if (!rd_q) begin
            rd_q       <= 1'b1;
            wait_cnt_q <= '0;
          end else if (!mem_waitrequest) begin
            mon_q   <= mem_rdata;
            rd_q    <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
            if (inc_q) addr_q <= addr_inc_d;
            if (mem_rdata != wdata_q) err_q <= 1'b1;
          end else if (timeout_d) begin
            rd_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
          if (any_stb_d) err_q <= 1'b1;
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr      = addr_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_wdata     = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule
